// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// The optional bne support is selected by the MIPS_CTRL_BNE_EN macro.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEXE = 4'd9,
        JUMP    = 4'd10,
        ADDIWB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// Combinational R-type Funct decode into an ALU operation code.
// Unknown Funct codes fall back to add and raise bad_funct.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       bad_funct
);

    always_comb begin
        alu_ctrl  = ALU_ADD;
        bad_funct = 1'b0;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            default: bad_funct = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM driving datapath enables, mux selects and AluCtrl.
// Define MIPS_CTRL_BNE_EN to accept bne (opcode 000101) as a branch.
//
// state   | meaning
// --------+-------------------------------------------------------
// FETCH   | read instruction at PC, PC+4; IR/PC load on last cycle
// DECODE  | register read, branch target precompute, opcode dispatch
// MEMADR  | effective address rs + imm for lw/sw
// MEMRD   | data memory read, held MEM_LAT cycles
// MEMWB   | write loaded data to rt
// MEMWR   | data memory write
// EXECUTE | R-type ALU operation
// ALUWB   | write ALU result to rd (suppressed for bad funct)
// BRANCH  | compare rs/rt, load branch target when taken
// ADDIEXE | rs + imm
// ADDIWB  | write addi result to rt
// JUMP    | load jump target
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] AluCtrl,
    output logic       Illegal
);

    localparam logic [3:0] MEM_TC = 4'(MEM_LAT - 1);

    state_t     state, state_nxt;
    logic [3:0] mem_cnt, mem_cnt_nxt;
    logic       mem_last;
    logic       bad_funct_q;
    logic       branch_taken;
    logic [2:0] dec_alu;
    logic       dec_bad;

    mips_alu_decoder u_alu_dec (
        .funct     (Funct),
        .alu_ctrl  (dec_alu),
        .bad_funct (dec_bad)
    );

    assign mem_last = (mem_cnt == MEM_TC);

`ifdef MIPS_CTRL_BNE_EN
    logic is_bne_q;

    always_ff @(posedge clk) begin
        if (reset)
            is_bne_q <= 1'b0;
        else if (state == DECODE)
            is_bne_q <= (Opcode == OP_BNE);
    end

    assign branch_taken = is_bne_q ? !Zero : Zero;
`else
    assign branch_taken = Zero;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            mem_cnt     <= 4'd0;
            bad_funct_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            mem_cnt <= mem_cnt_nxt;
            if (state == EXECUTE)
                bad_funct_q <= dec_bad;
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_cnt_nxt = 4'd0;
        PCEn        = 1'b0;
        IorD        = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RT;
        PCSrc       = PCSRC_ALU;
        AluCtrl     = ALU_ADD;
        Illegal     = 1'b0;

        case (state)
            FETCH: begin
                ALUSrcB = SRCB_FOUR;
                if (mem_last) begin
                    IRWrite   = 1'b1;
                    PCEn      = 1'b1;
                    state_nxt = DECODE;
                end else begin
                    mem_cnt_nxt = mem_cnt + 4'd1;
                end
            end
            DECODE: begin
                ALUSrcB = SRCB_IMMSH;
                case (Opcode)
                    OP_RTYPE:     state_nxt = EXECUTE;
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_BEQ:       state_nxt = BRANCH;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       state_nxt = BRANCH;
`endif
                    OP_ADDI:      state_nxt = ADDIEXE;
                    OP_J:         state_nxt = JUMP;
                    default: begin
                        Illegal   = 1'b1;
                        state_nxt = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                state_nxt = (Opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                IorD = 1'b1;
                if (mem_last)
                    state_nxt = MEMWB;
                else
                    mem_cnt_nxt = mem_cnt + 4'd1;
            end
            MEMWB: begin
                MemtoReg  = 1'b1;
                RegWrite  = 1'b1;
                state_nxt = FETCH;
            end
            MEMWR: begin
                IorD      = 1'b1;
                MemWrite  = 1'b1;
                state_nxt = FETCH;
            end
            EXECUTE: begin
                ALUSrcA   = 1'b1;
                AluCtrl   = dec_alu;
                state_nxt = ALUWB;
            end
            ALUWB: begin
                RegDst    = 1'b1;
                RegWrite  = !bad_funct_q;
                state_nxt = FETCH;
            end
            BRANCH: begin
                ALUSrcA   = 1'b1;
                AluCtrl   = ALU_SUB;
                PCSrc     = PCSRC_ALUOUT;
                PCEn      = branch_taken;
                state_nxt = FETCH;
            end
            ADDIEXE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                state_nxt = ADDIWB;
            end
            ADDIWB: begin
                RegWrite  = 1'b1;
                state_nxt = FETCH;
            end
            JUMP: begin
                PCSrc     = PCSRC_JUMP;
                PCEn      = 1'b1;
                state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase

        // Reset is synchronous, so outputs are quietened here to keep an aborted instruction from writing.
        if (reset) begin
            PCEn     = 1'b0;
            IorD     = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegDst   = 1'b0;
            MemtoReg = 1'b0;
            RegWrite = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = SRCB_RT;
            PCSrc    = PCSRC_ALU;
            AluCtrl  = ALU_ADD;
            Illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: two controllers (MEM_LAT 1 and 3) compared per cycle
// against an instruction-level model of the expected control word sequence.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluctrl;
        logic       illegal;
    } ctl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, reset_b;
    logic [5:0] op_a, fn_a, op_b, fn_b;
    logic       zero_a, zero_b;

    logic       pcen_a, iord_a, memwrite_a, irwrite_a, regdst_a, memtoreg_a, regwrite_a, alusrca_a, illegal_a;
    logic [1:0] alusrcb_a, pcsrc_a;
    logic [2:0] aluctrl_a;
    logic       pcen_b, iord_b, memwrite_b, irwrite_b, regdst_b, memtoreg_b, regwrite_b, alusrca_b, illegal_b;
    logic [1:0] alusrcb_b, pcsrc_b;
    logic [2:0] aluctrl_b;

    ctl_t obs_a, obs_b;
    assign obs_a = {pcen_a, iord_a, memwrite_a, irwrite_a, regdst_a, memtoreg_a,
                    regwrite_a, alusrca_a, alusrcb_a, pcsrc_a, aluctrl_a, illegal_a};
    assign obs_b = {pcen_b, iord_b, memwrite_b, irwrite_b, regdst_b, memtoreg_b,
                    regwrite_b, alusrca_b, alusrcb_b, pcsrc_b, aluctrl_b, illegal_b};

    mips_multicycle_ctrl #(.MEM_LAT(1)) dut_a (
        .clk(clk), .reset(reset_a), .Opcode(op_a), .Funct(fn_a), .Zero(zero_a),
        .PCEn(pcen_a), .IorD(iord_a), .MemWrite(memwrite_a), .IRWrite(irwrite_a),
        .RegDst(regdst_a), .MemtoReg(memtoreg_a), .RegWrite(regwrite_a),
        .ALUSrcA(alusrca_a), .ALUSrcB(alusrcb_a), .PCSrc(pcsrc_a),
        .AluCtrl(aluctrl_a), .Illegal(illegal_a)
    );

    mips_multicycle_ctrl #(.MEM_LAT(3)) dut_b (
        .clk(clk), .reset(reset_b), .Opcode(op_b), .Funct(fn_b), .Zero(zero_b),
        .PCEn(pcen_b), .IorD(iord_b), .MemWrite(memwrite_b), .IRWrite(irwrite_b),
        .RegDst(regdst_b), .MemtoReg(memtoreg_b), .RegWrite(regwrite_b),
        .ALUSrcA(alusrca_b), .ALUSrcB(alusrcb_b), .PCSrc(pcsrc_b),
        .AluCtrl(aluctrl_b), .Illegal(illegal_b)
    );

    int   checks = 0;
    int   errors = 0;
    ctl_t exp_q[$];

    function automatic ctl_t idle_word();
        ctl_t c = '0;
        c.aluctrl = 3'b010;
        return c;
    endfunction

    function automatic bit op_known(input logic [5:0] op);
        bit k = (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd4) ||
                (op == 6'd8) || (op == 6'd2);
`ifdef MIPS_CTRL_BNE_EN
        k = k || (op == 6'd5);
`endif
        return k;
    endfunction

    // ALU code for an R-type funct; 4'hF marks an unsupported funct
    function automatic logic [3:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'd32:   return 4'b0010;
            6'd34:   return 4'b0110;
            6'd36:   return 4'b0000;
            6'd37:   return 4'b0001;
            6'd42:   return 4'b0111;
            default: return 4'hF;
        endcase
    endfunction

    // Expected control words for one whole instruction, cycle by cycle.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z, input int lat);
        ctl_t c;
        exp_q.delete();
        for (int i = 0; i < lat; i++) begin
            c = idle_word();
            c.alusrcb = 2'b01;
            if (i == lat - 1) begin
                c.irwrite = 1'b1;
                c.pcen    = 1'b1;
            end
            exp_q.push_back(c);
        end
        c = idle_word();
        c.alusrcb = 2'b11;
        c.illegal = !op_known(op);
        exp_q.push_back(c);
        if (!op_known(op)) return;
        case (op)
            6'd0: begin
                c = idle_word();
                c.alusrca = 1'b1;
                c.aluctrl = (funct_alu(fn) == 4'hF) ? 3'b010 : funct_alu(fn)[2:0];
                exp_q.push_back(c);
                c = idle_word();
                c.regdst   = 1'b1;
                c.regwrite = (funct_alu(fn) != 4'hF);
                exp_q.push_back(c);
            end
            6'd35, 6'd43: begin
                c = idle_word();
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                exp_q.push_back(c);
                if (op == 6'd35) begin
                    for (int i = 0; i < lat; i++) begin
                        c = idle_word();
                        c.iord = 1'b1;
                        exp_q.push_back(c);
                    end
                    c = idle_word();
                    c.memtoreg = 1'b1;
                    c.regwrite = 1'b1;
                    exp_q.push_back(c);
                end else begin
                    c = idle_word();
                    c.iord     = 1'b1;
                    c.memwrite = 1'b1;
                    exp_q.push_back(c);
                end
            end
            6'd4, 6'd5: begin
                c = idle_word();
                c.alusrca = 1'b1;
                c.aluctrl = 3'b110;
                c.pcsrc   = 2'b01;
                c.pcen    = (op == 6'd4) ? z : !z;
                exp_q.push_back(c);
            end
            6'd8: begin
                c = idle_word();
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                exp_q.push_back(c);
                c = idle_word();
                c.regwrite = 1'b1;
                exp_q.push_back(c);
            end
            default: begin
                c = idle_word();
                c.pcsrc = 2'b10;
                c.pcen  = 1'b1;
                exp_q.push_back(c);
            end
        endcase
    endtask

    task automatic compare(input bit use_b, input string tag, input int cyc, input ctl_t expv);
        ctl_t o;
        o = use_b ? obs_b : obs_a;
        checks++;
        assert (o === expv) else begin
            errors++;
            $error("FAIL %s cyc %0d observed %h expected %h", tag, cyc, o, expv);
        end
    endtask

    // Called just after a rising edge; runs ncyc cycles of the instruction (negative = all).
    task automatic run(input bit use_b, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int ncyc, input string tag);
        int n;
        build(op, fn, z, use_b ? 3 : 1);
        if (use_b) begin
            op_b = op; fn_b = fn; zero_b = z;
        end else begin
            op_a = op; fn_a = fn; zero_a = z;
        end
        n = (ncyc < 0) ? exp_q.size() : ncyc;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            compare(use_b, tag, i, exp_q[i]);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold_reset(input bit use_b, input int ncyc, input string tag);
        if (use_b) reset_b = 1'b1; else reset_a = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            compare(use_b, tag, i, idle_word());
            @(posedge clk);
            #1;
        end
        if (use_b) reset_b = 1'b0; else reset_a = 1'b0;
    endtask

    task automatic rand_instr(input bit use_b);
        logic [5:0] op, fn;
        logic       z;
        logic [5:0] good_fn [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
        z  = 1'(($urandom & 32'd1));
        fn = 6'($urandom_range(0, 63));
        case ($urandom_range(0, 8))
            0: begin op = 6'd0; fn = good_fn[$urandom_range(0, 4)]; end
            1: begin
                op = 6'd0;
                while (funct_alu(fn) != 4'hF) fn = 6'($urandom_range(0, 63));
            end
            2: op = 6'd35;
            3: op = 6'd43;
            4: op = 6'd4;
            5: op = 6'd5;
            6: op = 6'd8;
            7: op = 6'd2;
            default: begin
                op = 6'($urandom_range(0, 63));
                while (op_known(op)) op = 6'($urandom_range(0, 63));
            end
        endcase
        run(use_b, op, fn, z, -1, "rand");
    endtask

    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        op_a = '0; fn_a = '0; zero_a = 1'b0;
        op_b = '0; fn_b = '0; zero_b = 1'b0;

        hold_reset(1'b0, 3, "reset_init");
        run(1'b0, 6'd0, 6'd32, 1'b0, -1, "add");
        run(1'b0, 6'd35, 6'd0, 1'b0, 4, "lw_abort");
        hold_reset(1'b0, 3, "reset_memwb");
        run(1'b0, 6'd43, 6'd0, 1'b0, -1, "sw");
        run(1'b0, 6'd4, 6'd0, 1'b1, -1, "beq_taken");
        run(1'b0, 6'd4, 6'd0, 1'b0, -1, "beq_not");
        run(1'b0, 6'd63, 6'd0, 1'b0, -1, "illegal");
        run(1'b0, 6'd0, 6'd7, 1'b0, -1, "bad_funct");
        run(1'b0, 6'd5, 6'd0, 1'b0, -1, "bne");
        run(1'b0, 6'd2, 6'd0, 1'b0, -1, "j");
        run(1'b0, 6'd8, 6'd0, 1'b0, -1, "addi");
        run(1'b0, 6'd0, 6'd34, 1'b0, -1, "sub");
        run(1'b0, 6'd0, 6'd36, 1'b0, -1, "and");
        run(1'b0, 6'd0, 6'd37, 1'b0, -1, "or");
        run(1'b0, 6'd0, 6'd42, 1'b0, -1, "slt");
        run(1'b0, 6'd0, 6'd32, 1'b0, -1, "add_after_bad");
        for (int i = 0; i < 60; i++) rand_instr(1'b0);
        reset_a = 1'b1;

        hold_reset(1'b1, 2, "reset_b");
        run(1'b1, 6'd35, 6'd0, 1'b0, -1, "lw_lat3");
        run(1'b1, 6'd43, 6'd0, 1'b0, -1, "sw_lat3");
        run(1'b1, 6'd4, 6'd0, 1'b1, -1, "beq_lat3");
        run(1'b1, 6'd62, 6'd0, 1'b0, -1, "illegal_lat3");
        for (int i = 0; i < 30; i++) rand_instr(1'b1);
        run(1'b1, 6'd2, 6'd0, 1'b0, -1, "j_lat3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
